message_sequencer: RTL and testbench

Playback controller for the on-chip text messages ("Guatemala", "Quetzal"). It latches the message selection from the switches and paces characters with a programmable prescaler. Each character is handed to the downstream display/UART sink over a valid/ready handshake, so the character datapath no longer free-runs off the raw clock. It sits between the top-level `ui_in` switch decode and the `uo_out` character output.

---
 rtl/message_pkg.sv | 28 ++
 rtl/message_rom.sv | 28 ++
 rtl/message_sequencer.sv | 109 ++++++++++
 tb/tb_message_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/message_pkg.sv
// Shared types and constants for the text-message playback block:
// FSM encoding, message lengths/ids and the character tables.
package message_pkg;

  localparam int unsigned CHAR_W = 8;
  localparam int unsigned IDX_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  localparam int unsigned LEN_GUATEMALA = 9;
  localparam int unsigned LEN_QUETZAL   = 7;

  localparam logic MSG_GUATEMALA = 1'b0;
  localparam logic MSG_QUETZAL   = 1'b1;

  localparam logic [0:LEN_GUATEMALA-1][CHAR_W-1:0] GUATEMALA_CHARS = {
    8'h47, 8'h75, 8'h61, 8'h74, 8'h65, 8'h6D, 8'h61, 8'h6C, 8'h61
  };

  localparam logic [0:LEN_QUETZAL-1][CHAR_W-1:0] QUETZAL_CHARS = {
    8'h51, 8'h75, 8'h65, 8'h74, 8'h7A, 8'h61, 8'h6C
  };

endpackage

// File: rtl/message_rom.sv
// Combinational character lookup: (msg_id, idx) -> (character, last flag).
// Any index past the end of a message reads as NUL and flags last.
module message_rom
  import message_pkg::*;
(
  input  logic              msg_id,
  input  logic [IDX_W-1:0]  idx,
  output logic [CHAR_W-1:0] ch,
  output logic              last
);

  always_comb begin
    ch   = 8'h00;
    last = 1'b1;
    if (msg_id == MSG_QUETZAL) begin
      if (idx < IDX_W'(LEN_QUETZAL)) begin
        ch   = QUETZAL_CHARS[idx[2:0]];
        last = (idx == IDX_W'(LEN_QUETZAL - 1));
      end
    end else begin
      if (idx < IDX_W'(LEN_GUATEMALA)) begin
        ch   = GUATEMALA_CHARS[idx];
        last = (idx == IDX_W'(LEN_GUATEMALA - 1));
      end
    end
  end

endmodule

// File: rtl/message_sequencer.sv
// Paced playback of the on-chip text messages towards a valid/ready sink.
// A reloadable countdown spaces characters; the sink may stall indefinitely.
module message_sequencer
  import message_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [1:0]        sel,
  input  logic              start,
  input  logic              loop,
  input  logic              hold,
  input  logic [DIV_W-1:0]  div,
  output logic [CHAR_W-1:0] char_out,
  output logic              char_valid,
  input  logic              char_ready,
  output logic [IDX_W-1:0]  idx,
  output logic              busy,
  output logic              msg_done
);

  state_t             state;
  state_t             state_nxt;
  logic [DIV_W-1:0]   cnt;
  logic               msg_id;
  logic [CHAR_W-1:0]  rom_char;
  logic               rom_last;
  logic               go;
  logic               tick;
  logic               accept;

  assign go     = start && ena;
  assign tick   = ena && !hold;
  assign accept = char_ready;

  message_rom u_rom (
    .msg_id (msg_id),
    .idx    (idx),
    .ch     (rom_char),
    .last   (rom_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (go) state_nxt = S_WAIT;
      S_WAIT:    if (tick && cnt == '0) state_nxt = S_PRESENT;
      S_PRESENT: if (accept) state_nxt = (rom_last && !loop) ? S_IDLE : S_WAIT;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE);
    char_valid = (state == S_PRESENT);
  end

  // Pacing counter, message selection and the character/index registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      char_out <= 8'h00;
      idx      <= '0;
      msg_done <= 1'b0;
      cnt      <= '0;
      msg_id   <= 1'b0;
    end else begin
      msg_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            msg_id <= sel[1] ^ sel[0];
            idx    <= '0;
            cnt    <= div;
          end
        end
        S_WAIT: begin
          if (tick) begin
            if (cnt != '0) cnt      <= cnt - DIV_W'(1);
            else           char_out <= rom_char;
          end
        end
        S_PRESENT: begin
          if (accept) begin
            if (rom_last) begin
              msg_done <= 1'b1;
              if (loop) begin
                msg_id <= sel[1] ^ sel[0];
                idx    <= '0;
                cnt    <= div;
              end
            end else begin
              idx <= idx + IDX_W'(1);
              cnt <= div;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_message_sequencer.sv
// Directed self-checking bench for message_sequencer.
module tb_message_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [1:0]  sel;
  logic        start;
  logic        loop;
  logic        hold;
  logic [15:0] div;
  logic [7:0]  char_out;
  logic        char_valid;
  logic        char_ready;
  logic [3:0]  idx;
  logic        busy;
  logic        msg_done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] guat [9] = '{8'h47, 8'h75, 8'h61, 8'h74, 8'h65, 8'h6D, 8'h61, 8'h6C, 8'h61};
  logic [7:0] quet [7] = '{8'h51, 8'h75, 8'h65, 8'h74, 8'h7A, 8'h61, 8'h6C};

  always #5 clk = ~clk;

  message_sequencer #(.DIV_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .sel        (sel),
    .start      (start),
    .loop       (loop),
    .hold       (hold),
    .div        (div),
    .char_out   (char_out),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .idx        (idx),
    .busy       (busy),
    .msg_done   (msg_done)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Advance until char_valid is seen; c = number of edges taken (bounded).
  task automatic wait_valid(output int c);
    c = 0;
    while (!char_valid && c < 100) begin
      step;
      c++;
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    start = 1'b0;
    step;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    total_cnt++;
    if ({char_out, char_valid, idx, busy, msg_done} !== 15'd0)
      $display("FAIL reset_values: got out=%h v=%b idx=%0d busy=%b done=%b, want all zero",
               char_out, char_valid, idx, busy, msg_done);
    else pass_cnt++;
  endtask

  task automatic test_guatemala;
    int c;
    sel = 2'b00; div = 16'd3; char_ready = 1'b1; loop = 1'b0;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      wait_valid(c);
      total_cnt++;
      if (c !== 4 || char_out !== guat[k] || idx !== 4'(k)) begin
        $display("FAIL guat_char%0d: got gap=%0d ch=%h idx=%0d, want gap=4 ch=%h idx=%0d",
                 k, c, char_out, idx, guat[k], k);
      end else pass_cnt++;
      step;
      total_cnt++;
      if (msg_done !== (k == 8)) $display("FAIL guat_done%0d: got %b want %b", k, msg_done, k == 8);
      else pass_cnt++;
    end
    total_cnt++;
    if (busy !== 1'b0 || char_valid !== 1'b0)
      $display("FAIL guat_idle: got busy=%b valid=%b want 0 0", busy, char_valid);
    else pass_cnt++;
  endtask

  task automatic test_quetzal_loop;
    int c;
    logic seq [3] = '{1'b1, 1'b1, 1'b0};
    sel = 2'b01; div = 16'd0; char_ready = 1'b1; loop = 1'b1;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      int len = seq[r] ? 7 : 9;
      for (int k = 0; k < len; k++) begin
        logic [7:0] exp_ch;
        exp_ch = seq[r] ? quet[k] : guat[k];
        wait_valid(c);
        total_cnt++;
        if (c !== 1 || char_out !== exp_ch || idx !== 4'(k))
          $display("FAIL loop_r%0d_c%0d: got gap=%0d ch=%h idx=%0d, want gap=1 ch=%h idx=%0d",
                   r, k, c, char_out, idx, exp_ch, k);
        else pass_cnt++;
        if (r == 1 && k == 3) sel = 2'b00;
        step;
        total_cnt++;
        if (msg_done !== (k == len - 1))
          $display("FAIL loop_done_r%0d_c%0d: got %b want %b", r, k, msg_done, k == len - 1);
        else pass_cnt++;
      end
      if (r == 1) loop = 1'b0;
    end
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL loop_end_idle: got busy=%b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_backpressure;
    int c;
    sel = 2'b00; div = 16'd1; char_ready = 1'b0; loop = 1'b0;
    start = 1'b1;
    step;
    start = 1'b0;
    wait_valid(c);
    total_cnt++;
    if (c !== 2 || char_out !== 8'h47) $display("FAIL bp_first: got gap=%0d ch=%h want gap=2 ch=47", c, char_out);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      step;
      total_cnt++;
      if (char_valid !== 1'b1 || char_out !== 8'h47 || idx !== 4'd0)
        $display("FAIL bp_stall%0d: got v=%b ch=%h idx=%0d want v=1 ch=47 idx=0", i, char_valid, char_out, idx);
      else pass_cnt++;
    end
    char_ready = 1'b1;
    step;
    char_ready = 1'b0;
    total_cnt++;
    if (char_valid !== 1'b0 || idx !== 4'd1)
      $display("FAIL bp_release: got v=%b idx=%0d want v=0 idx=1", char_valid, idx);
    else pass_cnt++;
    wait_valid(c);
    step;
    step;
    total_cnt++;
    if (c !== 2 || char_out !== 8'h75 || idx !== 4'd1 || char_valid !== 1'b1)
      $display("FAIL bp_single: got gap=%0d ch=%h idx=%0d v=%b want gap=2 ch=75 idx=1 v=1",
               c, char_out, idx, char_valid);
    else pass_cnt++;
    do_reset;
  endtask

  task automatic test_hold;
    int c;
    sel = 2'b10; div = 16'd2; char_ready = 1'b1; loop = 1'b0;
    start = 1'b1;
    step;
    start = 1'b0;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start = (i == 1);
      step;
      total_cnt++;
      if (char_valid !== 1'b0 || busy !== 1'b1)
        $display("FAIL hold_wait%0d: got v=%b busy=%b want v=0 busy=1", i, char_valid, busy);
      else pass_cnt++;
    end
    start = 1'b0;
    hold = 1'b0;
    wait_valid(c);
    total_cnt++;
    if (c !== 3 || char_out !== 8'h51 || idx !== 4'd0)
      $display("FAIL hold_delay: got gap=%0d ch=%h idx=%0d want gap=3 ch=51 idx=0", c, char_out, idx);
    else pass_cnt++;
    start = 1'b1;
    step;
    start = 1'b0;
    wait_valid(c);
    total_cnt++;
    if (c !== 3 || char_out !== 8'h75 || idx !== 4'd1)
      $display("FAIL busy_start: got gap=%0d ch=%h idx=%0d want gap=3 ch=75 idx=1", c, char_out, idx);
    else pass_cnt++;
    do_reset;
  endtask

  task automatic test_start_at_done;
    int c;
    sel = 2'b01; div = 16'd0; char_ready = 1'b1; loop = 1'b0;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      wait_valid(c);
      if (k == 6) start = 1'b1;
      step;
    end
    total_cnt++;
    if (msg_done !== 1'b1 || busy !== 1'b0)
      $display("FAIL done_start_idle: got done=%b busy=%b want done=1 busy=0", msg_done, busy);
    else pass_cnt++;
    step;
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1 || idx !== 4'd0)
      $display("FAIL done_start_take: got busy=%b idx=%0d want busy=1 idx=0", busy, idx);
    else pass_cnt++;
    do_reset;
  endtask

  task automatic test_reset_mid;
    int c;
    sel = 2'b00; div = 16'd0; char_ready = 1'b1; loop = 1'b0;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_valid(c);
      step;
    end
    wait_valid(c);
    total_cnt++;
    if (idx !== 4'd4 || char_out !== 8'h65)
      $display("FAIL mid_at4: got idx=%0d ch=%h want idx=4 ch=65", idx, char_out);
    else pass_cnt++;
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    total_cnt++;
    if ({char_out, char_valid, idx, busy, msg_done} !== 15'd0)
      $display("FAIL mid_reset: got out=%h v=%b idx=%0d busy=%b done=%b want all zero",
               char_out, char_valid, idx, busy, msg_done);
    else pass_cnt++;
    start = 1'b1;
    step;
    start = 1'b0;
    wait_valid(c);
    total_cnt++;
    if (c !== 1 || idx !== 4'd0 || char_out !== 8'h47)
      $display("FAIL mid_restart: got gap=%0d idx=%0d ch=%h want gap=1 idx=0 ch=47", c, idx, char_out);
    else pass_cnt++;
    do_reset;
  endtask

  task automatic test_ena;
    int c;
    sel = 2'b11; div = 16'd2; char_ready = 1'b1; loop = 1'b0;
    ena = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL ena_low%0d: got busy=%b want 0", i, busy);
      else pass_cnt++;
    end
    ena = 1'b1;
    step;
    start = 1'b0;
    wait_valid(c);
    total_cnt++;
    if (c !== 3 || char_out !== 8'h47 || idx !== 4'd0)
      $display("FAIL ena_start: got gap=%0d ch=%h idx=%0d want gap=3 ch=47 idx=0", c, char_out, idx);
    else pass_cnt++;
    do_reset;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; sel = 2'b00; start = 1'b0; loop = 1'b0;
    hold = 1'b0; div = 16'd0; char_ready = 1'b0;
    test_reset;
    test_guatemala;
    test_quetzal_loop;
    test_backpressure;
    test_hold;
    test_start_at_done;
    test_reset_mid;
    test_ena;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
